base3_digit_serializer: RTL

//  Downstream stage of the binary-to-base-3 converter. Captures the packed 32-bit base-3 word
//  (16 trits, 2 bits each, trit 0 in [1:0]) on the converter's done pulse.

---
 rtl/base3_pkg.sv | 21 ++
 rtl/base3_digit_serializer_if.sv | 12 +
 rtl/trit_char_enc.sv | 18 +
 rtl/base3_digit_serializer.sv | 112 +++++++++++
 4 files changed

// File: rtl/base3_pkg.sv
// Shared definitions for the base-3 converter path: trit codes, FSM encoding, ASCII defaults.
package base3_pkg;

  localparam int unsigned TRIT_W = 2;

  localparam logic [TRIT_W-1:0] TRIT_ZERO = 2'b00;
  localparam logic [TRIT_W-1:0] TRIT_ONE  = 2'b01;
  localparam logic [TRIT_W-1:0] TRIT_TWO  = 2'b10;
  localparam logic [TRIT_W-1:0] TRIT_BAD  = 2'b11;

  localparam logic [7:0] ASCII_ZERO_DEF = 8'h30;
  localparam logic [7:0] ERR_CHAR_DEF   = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/base3_digit_serializer_if.sv
// Valid/ready ASCII byte stream with an end-of-frame marker.
interface base3_digit_serializer_if;

  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       char_last;

  modport master (output char_out, output char_valid, output char_last, input char_ready);
  modport slave  (input char_out, input char_valid, input char_last, output char_ready);

endinterface

// File: rtl/trit_char_enc.sv
// Combinational trit -> ASCII character map; illegal code 2'b11 maps to ERR_CHAR and raises bad_c.
module trit_char_enc
  import base3_pkg::*;
#(
  parameter logic [7:0] ASCII_ZERO = ASCII_ZERO_DEF,
  parameter logic [7:0] ERR_CHAR   = ERR_CHAR_DEF
) (
  input  logic [TRIT_W-1:0] trit,
  output logic [7:0]        ch_c,
  output logic              bad_c
);

  always_comb begin
    bad_c = (trit == TRIT_BAD);
    ch_c  = bad_c ? ERR_CHAR : (ASCII_ZERO + 8'(trit));
  end

endmodule

// File: rtl/base3_digit_serializer.sv
// Captures a packed base-3 word and streams its trits MSB-first as ASCII characters.
// Optional build macro BASE3_ZERO_SUPPRESS_EN skips leading zero trits (at least one is sent).
module base3_digit_serializer
  import base3_pkg::*;
#(
  parameter int unsigned DIGITS     = 16,
  parameter logic [7:0]  ASCII_ZERO = ASCII_ZERO_DEF,
  parameter logic [7:0]  ERR_CHAR   = ERR_CHAR_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [TRIT_W*DIGITS-1:0] base3_no,
  input  logic                     load,
  output logic                     busy,
  base3_digit_serializer_if.master char_if,
  output logic                     frame_done,
  output logic                     err
);

  localparam int unsigned WORD_W = TRIT_W * DIGITS;
  localparam int unsigned CNT_W  = $clog2(DIGITS + 1);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_d;
  logic               bad_q;
  logic               hs_c;
  logic [7:0]         enc_ch_c;
  logic               enc_bad_c;

  // Next-state, shift register and counter update
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    err_d   = err;
    hs_c    = char_if.char_valid && char_if.char_ready;

    case (state_q)
      ST_IDLE: begin
        if (load) begin
          shreg_d = base3_no;
          cnt_d   = CNT_W'(DIGITS);
          err_d   = 1'b0;
`ifdef BASE3_ZERO_SUPPRESS_EN
          state_d = ST_SCAN;
`else
          state_d = ST_SEND;
`endif
        end
      end
`ifdef BASE3_ZERO_SUPPRESS_EN
      ST_SCAN: begin
        if ((shreg_q[WORD_W-1 -: TRIT_W] == TRIT_ZERO) && (cnt_q > CNT_W'(1))) begin
          shreg_d = shreg_q << TRIT_W;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_SEND;
        end
      end
`endif
      ST_SEND: begin
        if (hs_c) begin
          shreg_d = shreg_q << TRIT_W;
          cnt_d   = cnt_q - CNT_W'(1);
          if (bad_q) err_d = 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Encode the trit that will be on top after this edge, so outputs can be registered
  trit_char_enc #(
    .ASCII_ZERO (ASCII_ZERO),
    .ERR_CHAR   (ERR_CHAR)
  ) u_enc (
    .trit  (shreg_d[WORD_W-1 -: TRIT_W]),
    .ch_c  (enc_ch_c),
    .bad_c (enc_bad_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      shreg_q            <= '0;
      cnt_q              <= '0;
      bad_q              <= 1'b0;
      err                <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      char_if.char_out   <= '0;
      char_if.char_valid <= 1'b0;
      char_if.char_last  <= 1'b0;
    end else begin
      state_q            <= state_d;
      shreg_q            <= shreg_d;
      cnt_q              <= cnt_d;
      err                <= err_d;
      busy               <= (state_d == ST_SCAN) || (state_d == ST_SEND);
      frame_done         <= (state_d == ST_DONE);
      bad_q              <= (state_d == ST_SEND) && enc_bad_c;
      char_if.char_valid <= (state_d == ST_SEND);
      char_if.char_last  <= (state_d == ST_SEND) && (cnt_d == CNT_W'(1));
      char_if.char_out   <= (state_d == ST_SEND) ? enc_ch_c : 8'h00;
    end
  end

endmodule
